// File: rtl/cpu_clk_sequencer_pkg.sv
// State encodings for the CPU clock run/stop/step sequencer. The debug status
// register block uses them too.
package cpu_clk_sequencer_pkg;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STEP     = 2'd2,
        S_STOPPING = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cpu_clk_sequencer.sv
// Turns run/stop/step command pulses into clk_divider start/reset strobes and counts CPU edges.
// All outputs are registered, one cycle behind the command; there is no backpressure and commands that are not legal in the current state are dropped.
module cpu_clk_sequencer
    import cpu_clk_sequencer_pkg::*;
#(
    parameter int STEP_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_run_stb,
    input  logic                   i_stop_stb,
    input  logic                   i_step_stb,
    input  logic [STEP_WIDTH-1:0]  i_step_len,
    input  logic                   i_clr_cnt_stb,
    input  logic                   i_div_clk_rose,
    output logic                   o_div_start_stb,
    output logic                   o_div_reset_stb,
    output logic [STATE_WIDTH-1:0] o_state,
    output logic                   o_busy,
    output logic                   o_step_done,
    output logic                   o_step_abort,
    output logic [CNT_WIDTH-1:0]   o_cycle_cnt
);

    localparam logic [STEP_WIDTH-1:0] REM_ONE = STEP_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    seq_state_t            state_q, state_d;
    logic [STEP_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  start_q, start_d;
    logic                  rst_stb_q, rst_stb_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            rst_stb_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            rst_stb_q <= rst_stb_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        start_d   = 1'b0;
        rst_stb_d = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_run_stb) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end else if (i_step_stb) begin
                    if (i_step_len != '0) begin
                        rem_d   = i_step_len;
                        start_d = 1'b1;
                        state_d = S_STEP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (i_stop_stb) begin
                    rst_stb_d = 1'b1;
                    state_d   = S_STOPPING;
                end
            end
            S_STEP: begin
                if (i_stop_stb) begin
                    rst_stb_d = 1'b1;
                    abort_d   = 1'b1;
                    rem_d     = '0;
                    state_d   = S_STOPPING;
                end else if (i_run_stb) begin
                    // Divider is already counting, so just stop tracking the step.
                    rem_d   = '0;
                    state_d = S_RUN;
                end else if (i_div_clk_rose) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        rst_stb_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_STOPPING;
                    end
                end
            end
            S_STOPPING: begin
                // Single dead cycle keeps start and reset strobes apart.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt_stb) begin
            cnt_d = '0;
        end else if (i_div_clk_rose && (state_q == S_RUN || state_q == S_STEP)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign o_div_start_stb = start_q;
    assign o_div_reset_stb = rst_stb_q;
    assign o_state         = state_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_step_done     = done_q;
    assign o_step_abort    = abort_q;
    assign o_cycle_cnt     = cnt_q;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Directed vector bench for cpu_clk_sequencer: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (long runs, abort, reset, wrap).
module tb_cpu_clk_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run_stb, stop_stb, step_stb, clr_stb, rose;
    logic [7:0]  step_len;
    logic        start_stb, rst_stb, busy, done, abort;
    logic [1:0]  state;
    logic [15:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_clk_sequencer #(.STEP_WIDTH(8), .CNT_WIDTH(16)) dut (
        .i_clk           (clk),
        .i_reset_n       (reset_n),
        .i_run_stb       (run_stb),
        .i_stop_stb      (stop_stb),
        .i_step_stb      (step_stb),
        .i_step_len      (step_len),
        .i_clr_cnt_stb   (clr_stb),
        .i_div_clk_rose  (rose),
        .o_div_start_stb (start_stb),
        .o_div_reset_stb (rst_stb),
        .o_state         (state),
        .o_busy          (busy),
        .o_step_done     (done),
        .o_step_abort    (abort),
        .o_cycle_cnt     (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, STOPPING = 2'd3;

    typedef struct {
        logic        rst_n, run, stop, step;
        logic [7:0]  len;
        logic        clr, rose;
        logic        e_start, e_rst;
        logic [1:0]  e_state;
        logic        e_busy, e_done, e_abort;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic run, logic stop, logic step, logic [7:0] len,
                                logic clr, logic rose, logic e_start, logic e_rst, logic [1:0] e_state,
                                logic e_busy, logic e_done, logic e_abort, logic [15:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.run = run; v.stop = stop; v.step = step; v.len = len;
        v.clr = clr; v.rose = rose; v.e_start = e_start; v.e_rst = e_rst; v.e_state = e_state;
        v.e_busy = e_busy; v.e_done = e_done; v.e_abort = e_abort; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs from a negedge, return at the next negedge.
    task automatic apply(input logic rn, input logic r, input logic s, input logic st,
                         input logic [7:0] l, input logic c, input logic ro);
        reset_n = rn; run_stb = r; stop_stb = s; step_stb = st;
        step_len = l; clr_stb = c; rose = ro;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply(1, 0, 0, 0, 8'd0, 0, 0);
    endtask

    task automatic chk_all(input string tag, input logic e_start, input logic e_rst,
                           input logic [1:0] e_state, input logic e_busy, input logic e_done,
                           input logic e_abort, input logic [15:0] e_cnt);
        chk({tag, ".start"}, 32'(start_stb), 32'(e_start));
        chk({tag, ".rst"},   32'(rst_stb),   32'(e_rst));
        chk({tag, ".state"}, 32'(state),     32'(e_state));
        chk({tag, ".busy"},  32'(busy),      32'(e_busy));
        chk({tag, ".done"},  32'(done),      32'(e_done));
        chk({tag, ".abort"}, 32'(abort),     32'(e_abort));
        chk({tag, ".cnt"},   32'(cnt),       32'(e_cnt));
    endtask

    // Start and reset strobes must never be high together.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_checks++;
            if (start_stb && rst_stb) begin
                n_fail++;
                $display("FAIL strobe_overlap: start=%0b reset=%0b required not both at %0t",
                         start_stb, rst_stb, $time);
            end
        end
    end

    initial begin
        reset_n = 0; run_stb = 0; stop_stb = 0; step_stb = 0;
        step_len = 0; clr_stb = 0; rose = 0;

        //          rn run stp stp len  clr rose | start rst state     busy done abort cnt
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 0, 0,   0, 0, IDLE,     0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 1,   0, 0, IDLE,     0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 1, 0, 8'd0, 0, 0,   0, 0, IDLE,     0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 1, 0, 0, 8'd0, 0, 0,   1, 0, RUN,      1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 0,   0, 0, RUN,      1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, RUN,      1, 0, 0, 16'd1));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, RUN,      1, 0, 0, 16'd2));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, RUN,      1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 1, 0, 1, 8'd4, 0, 0,   0, 0, RUN,      1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 1, 0, 8'd0, 0, 0,   0, 1, STOPPING, 1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 1, 0, 0, 8'd0, 0, 1,   0, 0, IDLE,     0, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, IDLE,     0, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 1, 0,   0, 0, IDLE,     0, 0, 0, 16'd0));
        // step of 4 completes normally
        vecs.push_back(mk(1, 0, 0, 1, 8'd4, 0, 0,   1, 0, STEP,     1, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd1));
        vecs.push_back(mk(1, 0, 0, 1, 8'd9, 0, 0,   0, 0, STEP,     1, 0, 0, 16'd1));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd2));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 1, STOPPING, 1, 1, 0, 16'd4));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, IDLE,     0, 0, 0, 16'd4));
        // step of 4 aborted after two edges
        vecs.push_back(mk(1, 0, 0, 1, 8'd4, 0, 0,   1, 0, STEP,     1, 0, 0, 16'd4));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd5));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd6));
        vecs.push_back(mk(1, 0, 1, 0, 8'd0, 0, 0,   0, 1, STOPPING, 1, 0, 1, 16'd6));
        vecs.push_back(mk(1, 1, 0, 1, 8'd3, 0, 0,   0, 0, IDLE,     0, 0, 0, 16'd6));
        // zero-length step, then run+step priority
        vecs.push_back(mk(1, 0, 0, 1, 8'd0, 0, 0,   0, 0, IDLE,     0, 1, 0, 16'd6));
        vecs.push_back(mk(1, 1, 0, 1, 8'd3, 0, 0,   1, 0, RUN,      1, 0, 0, 16'd6));
        vecs.push_back(mk(1, 1, 1, 1, 8'd3, 0, 0,   0, 1, STOPPING, 1, 0, 0, 16'd6));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 0,   0, 0, IDLE,     0, 0, 0, 16'd6));
        // run during a step converts it to free running
        vecs.push_back(mk(1, 0, 0, 1, 8'd2, 0, 0,   1, 0, STEP,     1, 0, 0, 16'd6));
        vecs.push_back(mk(1, 0, 0, 0, 8'd0, 0, 1,   0, 0, STEP,     1, 0, 0, 16'd7));
        vecs.push_back(mk(1, 1, 0, 0, 8'd0, 0, 0,   0, 0, RUN,      1, 0, 0, 16'd7));

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].run, vecs[i].stop, vecs[i].step,
                  vecs[i].len, vecs[i].clr, vecs[i].rose);
            chk_all($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_rst, vecs[i].e_state,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_abort, vecs[i].e_cnt);
        end

        // Ten edges after run-during-step: the old step length must not auto-stop.
        for (int k = 0; k < 10; k++) begin
            apply(1, 0, 0, 0, 8'd0, 0, 1);
            chk_all($sformatf("runstep_rose%0d", k), 0, 0, RUN, 1, 0, 0, 16'(8 + k));
        end
        apply(1, 0, 1, 0, 8'd0, 0, 0);
        chk_all("runstep_stop", 0, 1, STOPPING, 1, 0, 0, 16'd17);
        idle_cycle();
        chk_all("runstep_idle", 0, 0, IDLE, 0, 0, 0, 16'd17);

        // Stop coincident with the edge: abort wins, the edge is still counted.
        apply(1, 0, 0, 1, 8'd3, 0, 0);
        chk_all("abortrose_start", 1, 0, STEP, 1, 0, 0, 16'd17);
        apply(1, 0, 0, 0, 8'd0, 0, 1);
        apply(1, 0, 1, 0, 8'd0, 0, 1);
        chk_all("abortrose_stop", 0, 1, STOPPING, 1, 0, 1, 16'd19);
        idle_cycle();
        chk_all("abortrose_idle", 0, 0, IDLE, 0, 0, 0, 16'd19);

        // Clear beats a coincident increment.
        apply(1, 1, 0, 0, 8'd0, 0, 0);
        apply(1, 0, 0, 0, 8'd0, 1, 1);
        chk("clr_vs_rose", 32'(cnt), 32'd0);
        apply(1, 0, 0, 0, 8'd0, 0, 1);
        chk("after_clr_rose", 32'(cnt), 32'd1);
        apply(1, 0, 1, 0, 8'd0, 0, 0);
        idle_cycle();

        // Reset in the middle of a step: no divider reset strobe, everything cleared.
        apply(1, 0, 0, 1, 8'd5, 0, 0);
        apply(1, 0, 0, 0, 8'd0, 0, 1);
        chk_all("midstep", 0, 0, STEP, 1, 0, 0, 16'd2);
        apply(0, 0, 0, 0, 8'd0, 0, 1);
        chk_all("midstep_reset", 0, 0, IDLE, 0, 0, 0, 16'd0);
        idle_cycle();
        chk_all("post_reset", 0, 0, IDLE, 0, 0, 0, 16'd0);

        // Counter wrap at 16 bits.
        apply(1, 1, 0, 0, 8'd0, 0, 0);
        for (int k = 0; k < 65535; k++) apply(1, 0, 0, 0, 8'd0, 0, 1);
        chk("cnt_ffff", 32'(cnt), 32'h0000_FFFF);
        apply(1, 0, 0, 0, 8'd0, 0, 1);
        chk("cnt_wrap", 32'(cnt), 32'd0);
        chk("wrap_state", 32'(state), 32'(RUN));

        idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
